// File: rtl/l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// A four-state FSM sequences read-miss refills and store write-throughs to memory.
module l1d_cache #(
    parameter int LINES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic        cpu_flush,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data,
    input  logic        mem_stall,
    output logic [1:0]  dbg_state
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    // Handshake: cpu_read/cpu_write are held until a cycle with cpu_stall=0, which
    // completes them at that edge; mem_read/mem_write are accepted in a cycle with mem_stall=0.
    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, WRITE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       data_q [LINES];
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [31:0]       lat_addr, lat_data;

    logic [IDX-1:0]    cpu_idx, lat_idx;
    logic [TAGW-1:0]   cpu_tag, lat_tag;
    logic              cpu_hit, lat_hit;
    logic              lat_ld, fill_en, upd_en, flush_en;
    logic              unused_low_bits;

    assign cpu_idx = cpu_address[IDX+1:2];
    assign cpu_tag = cpu_address[31:IDX+2];
    assign lat_idx = lat_addr[IDX+1:2];
    assign lat_tag = lat_addr[31:IDX+2];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    assign unused_low_bits = ^cpu_address[1:0];

    assign mem_address    = lat_addr;
    assign mem_write_data = lat_data;
    assign dbg_state      = state;

    always_comb begin
        state_nxt     = state;
        cpu_stall     = 1'b0;
        cpu_read_data = data_q[cpu_idx];
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        lat_ld        = 1'b0;
        fill_en       = 1'b0;
        upd_en        = 1'b0;
        flush_en      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_flush) begin
                    cpu_stall = 1'b1;
                    flush_en  = 1'b1;
                end else if (cpu_write) begin
                    cpu_stall = 1'b1;
                    lat_ld    = 1'b1;
                    state_nxt = WRITE;
                end else if (cpu_read && !cpu_hit) begin
                    cpu_stall = 1'b1;
                    lat_ld    = 1'b1;
                    state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_read  = 1'b1;
                cpu_stall = 1'b1;
                if (!mem_stall) state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                mem_read      = 1'b1;
                cpu_read_data = mem_data;
                fill_en       = 1'b1;
                state_nxt     = IDLE;
            end
            WRITE: begin
                mem_write = 1'b1;
                if (mem_stall) begin
                    cpu_stall = 1'b1;
                end else begin
                    upd_en    = lat_hit;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset silences every output and abandons any in-flight line update.
        if (!reset_n) begin
            cpu_stall     = 1'b0;
            cpu_read_data = '0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            lat_ld        = 1'b0;
            fill_en       = 1'b0;
            upd_en        = 1'b0;
            flush_en      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            valid_q  <= '0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            state <= state_nxt;
            if (lat_ld) begin
                lat_addr <= {cpu_address[31:2], 2'b00};
                lat_data <= cpu_write_data;
            end
            if (flush_en) valid_q <= '0;
            else if (fill_en) valid_q[lat_idx] <= 1'b1;
        end
    end

    // Line data and tags carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_q[lat_idx] <= mem_data;
            tag_q[lat_idx]  <= lat_tag;
        end else if (upd_en) begin
            data_q[lat_idx] <= lat_data;
        end
    end

endmodule

// File: tb/tb_l1d_cache.sv
// Randomized bench for l1d_cache: a word-addressed memory responder plus an abstract
// cache-residency model predicting hit/miss, latency and returned data.
module tb_l1d_cache;

    localparam int LINES = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
    logic        cpu_read, cpu_write, cpu_flush, cpu_stall;
    logic [31:0] mem_address, mem_write_data, mem_data;
    logic        mem_read, mem_write, mem_stall;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic [31:0] mem_m [logic [29:0]];
    bit          ref_valid [LINES];
    int unsigned ref_tag   [LINES];

    l1d_cache #(.LINES(LINES)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_flush(cpu_flush),
        .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_data(mem_data), .mem_stall(mem_stall), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_val(input logic [29:0] w);
        if (mem_m.exists(w)) return mem_m[w];
        return {2'b00, w} * 32'h9E3779B1 ^ 32'h5A5A1234;
    endfunction

    // Memory: read data appears the cycle after an accepted mem_read; stores land on acceptance.
    always @(posedge clock) begin
        if (mem_read && !mem_stall) mem_data <= mem_val(mem_address[31:2]);
        else mem_data <= $urandom;
        if (mem_write && !mem_stall) mem_m[mem_address[31:2]] = mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned w = a >> 2;
        return ref_valid[w % LINES] && (ref_tag[w % LINES] == w / LINES);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        int unsigned w = a >> 2;
        ref_valid[w % LINES] = 1'b1;
        ref_tag[w % LINES]   = w / LINES;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    endfunction

    function automatic logic ms_pattern(input int cyc, input int n_ms);
        if (cyc == 0) return 1'($urandom_range(0, 1));
        return (cyc <= n_ms) ? 1'b1 : 1'b0;
    endfunction

    // All driver tasks start and end on a falling edge.
    task automatic do_read(input logic [31:0] addr, input int n_ms);
        bit hit = model_hit(addr);
        int cyc = 0;
        int mr = 0;
        bit done = 0;
        logic [31:0] exp_d;
        exp_q.push_back(mem_val(addr[31:2]));
        cpu_address = addr; cpu_read = 1'b1; cpu_write = 1'b0; cpu_flush = 1'b0;
        cpu_write_data = $urandom;
        while (!done && cyc < 40) begin
            mem_stall = ms_pattern(cyc, n_ms);
            #2;
            if (mem_read) begin
                mr++;
                check("rd_mem_addr", mem_address, {addr[31:2], 2'b00});
            end
            check("rd_no_mem_write", {31'b0, mem_write}, 32'd0);
            if (!cpu_stall) begin
                done = 1;
                exp_d = exp_q.pop_front();
                check("rd_data", cpu_read_data, exp_d);
            end
            @(negedge clock);
            cyc++;
        end
        if (!done) void'(exp_q.pop_front());
        check("rd_done", {31'b0, done}, 32'd1);
        check("rd_stall_cycles", 32'(cyc - 1), hit ? 32'd0 : 32'(2 + n_ms));
        check("rd_mem_read_cycles", 32'(mr), hit ? 32'd0 : 32'(2 + n_ms));
        cpu_read = 1'b0;
        model_fill(addr);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int n_ms);
        int cyc = 0;
        int mw = 0;
        bit done = 0;
        cpu_address = addr; cpu_write_data = data; cpu_write = 1'b1; cpu_flush = 1'b0;
        cpu_read = 1'($urandom_range(0, 1));
        while (!done && cyc < 40) begin
            mem_stall = ms_pattern(cyc, n_ms);
            #2;
            if (mem_write) begin
                mw++;
                check("wr_mem_addr", mem_address, {addr[31:2], 2'b00});
                check("wr_mem_data", mem_write_data, data);
            end
            check("wr_no_mem_read", {31'b0, mem_read}, 32'd0);
            if (!cpu_stall) done = 1;
            @(negedge clock);
            cyc++;
        end
        check("wr_done", {31'b0, done}, 32'd1);
        check("wr_stall_cycles", 32'(cyc - 1), 32'(1 + n_ms));
        check("wr_mem_write_cycles", 32'(mw), 32'(1 + n_ms));
        cpu_write = 1'b0; cpu_read = 1'b0;
    endtask

    task automatic do_flush();
        cpu_flush = 1'b1;
        cpu_read  = 1'($urandom_range(0, 1));
        cpu_write = 1'($urandom_range(0, 1));
        cpu_address = $urandom;
        mem_stall = 1'b0;
        #2;
        check("flush_stall", {31'b0, cpu_stall}, 32'd1);
        check("flush_no_mem", {30'b0, mem_read, mem_write}, 32'd0);
        @(negedge clock);
        cpu_flush = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        #2;
        check("flush_stays_idle", {30'b0, mem_read, mem_write}, 32'd0);
        @(negedge clock);
        model_clear();
    endtask

    // Start a miss, walk it into the data-return cycle, then pulse reset.
    task automatic reset_in_wait(input logic [31:0] addr);
        cpu_address = addr; cpu_read = 1'b1; mem_stall = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2;
        check("rst_pre_mem_read", {31'b0, mem_read}, 32'd1);
        reset_n = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("rst_mem_read_drop", {31'b0, mem_read}, 32'd0);
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_read_data", cpu_read_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_address = '0; cpu_write_data = '0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_flush = 1'b0;
        mem_stall = 1'b0; mem_data = '0;
        model_clear();
        #3;
        check("reset_stall", {31'b0, cpu_stall}, 32'd0);
        check("reset_read_data", cpu_read_data, 32'd0);
        check("reset_mem_req", {30'b0, mem_read, mem_write}, 32'd0);
        check("reset_mem_addr", mem_address, 32'd0);
        check("reset_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        mem_m[30'h41] = 32'hCAFEBABE;
        do_read(32'h0000_0104, 0);
        do_read(32'h0000_0104, 0);
        do_read(32'h0000_0107, 0);
        do_write(32'h0000_0104, 32'h1111_1111, 0);
        do_read(32'h0000_0104, 0);
        do_write(32'h0000_0200, 32'h2222_2222, 0);
        do_read(32'h0000_0200, 0);
        do_read(32'h0000_0124, 0);
        do_read(32'h0000_0104, 0);
        do_read(32'h0000_0300, 3);
        do_write(32'h0000_0124, 32'h3333_3333, 2);
        do_flush();
        do_read(32'h0000_0104, 0);
        reset_in_wait(32'h0000_0400);
        do_read(32'h0000_0104, 0);
        do_read(32'h0000_0400, 1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int op;
            a = 32'h1000_0000 + 32'($urandom_range(0, 3) * LINES * 4)
                + 32'($urandom_range(0, LINES - 1) * 4) + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 99);
            if (op < 55) do_read(a, $urandom_range(0, 3));
            else if (op < 95) do_write(a, $urandom, $urandom_range(0, 3));
            else do_flush();
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
